serial_word_receiver: RTL and testbench

Serial-to-parallel receiver that consumes the serial output of the circular shift-right register, one bit per enabled clock. It reassembles the stream LSB-first into WIDTH-bit words and pulses a valid strobe for each completed word. It also runs an overlapping sliding-window pattern detector on the same stream and counts matches. It sits directly downstream of the shift register's `out` pin and feeds the display/check logic.

---
 rtl/serial_word_receiver.sv | 120 ++++++++++++
 tb/tb_serial_word_receiver.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_word_receiver.sv
// Serial-to-parallel receiver: reassembles an LSB-first bit stream into WIDTH-bit words
// and runs an overlapping sliding-window pattern detector with a saturating match counter.
module serial_word_receiver #(
   parameter int               WIDTH   = 5,
   parameter logic [WIDTH-1:0] PATTERN = 5'b10110
) (
   input  logic             clock,
   input  logic             clear,
   input  logic             serial_in,
   input  logic             enable,
   input  logic             sync,
   output logic [WIDTH-1:0] word,
   output logic             word_valid,
   output logic             busy,
   output logic             match,
   output logic [3:0]       match_count
);

   localparam int IDX_W  = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam int FILL_W = $clog2(WIDTH + 1);

   localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(WIDTH - 1);
   localparam logic [IDX_W-1:0]  FIRST_IDX = IDX_W'(1);
   localparam logic [FILL_W-1:0] FULL      = FILL_W'(WIDTH);
   localparam logic [FILL_W-1:0] ONE_BIT   = FILL_W'(1);

   typedef enum logic {
      IDLE,
      RECV
   } state_t;

   state_t            state;
   logic [IDX_W-1:0]  index;
   logic [WIDTH-1:0]  assembly;
   logic [WIDTH-1:0]  window;
   logic [FILL_W-1:0] fill;

   logic [WIDTH-1:0]  assembly_next;
   logic [WIDTH-1:0]  window_next;
   logic [FILL_W-1:0] fill_next;
   logic              starts_word;
   logic              completes_word;
   logic              hit;

   function automatic logic [3:0] sat_inc(input logic [3:0] count);
      return (count == 4'hF) ? count : count + 4'd1;
   endfunction

   // New bits enter at the MSB so the first bit of a word ends up in bit 0.
   always_comb begin
      assembly_next  = {serial_in, assembly[WIDTH-1:1]};
      window_next    = {serial_in, window[WIDTH-1:1]};
      starts_word    = enable && (sync || (state == IDLE));
      completes_word = enable && !starts_word && (index == LAST_IDX);

      fill_next = fill;
      if (sync) begin
         fill_next = enable ? ONE_BIT : '0;
      end else if (enable && (fill != FULL)) begin
         fill_next = fill + 1'b1;
      end

      hit = enable && (fill_next == FULL) && (window_next == PATTERN);
   end

   // Framing FSM; sync takes priority over the normal index progression.
   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         state      <= IDLE;
         index      <= '0;
         assembly   <= '0;
         word       <= '0;
         word_valid <= 1'b0;
         busy       <= 1'b0;
      end else begin
         word_valid <= 1'b0;
         if (enable) begin
            assembly <= assembly_next;
         end

         if (sync && !enable) begin
            state <= IDLE;
            index <= '0;
            busy  <= 1'b0;
         end else if (starts_word) begin
            state <= RECV;
            index <= FIRST_IDX;
            busy  <= 1'b1;
         end else if (completes_word) begin
            index      <= '0;
            word       <= assembly_next;
            word_valid <= 1'b1;
            busy       <= 1'b0;
         end else if (enable) begin
            index <= index + 1'b1;
            busy  <= 1'b1;
         end
      end
   end

   // Pattern detector runs on every accepted bit regardless of word framing.
   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         window      <= '0;
         fill        <= '0;
         match       <= 1'b0;
         match_count <= 4'd0;
      end else begin
         match <= hit;
         fill  <= fill_next;
         if (enable) begin
            window <= window_next;
         end
         if (hit) begin
            match_count <= sat_inc(match_count);
         end
      end
   end

endmodule

// File: tb/tb_serial_word_receiver.sv
// Self-checking bench for serial_word_receiver: directed scenarios plus a randomized
// run compared against a queue-based behavioural model.
module tb_serial_word_receiver;

   localparam int W = 5;
   localparam logic [W-1:0] PAT = 5'b10110;

   logic         clock = 1'b0;
   logic         clear = 1'b0;
   logic         serial_in = 1'b0;
   logic         enable = 1'b0;
   logic         sync = 1'b0;
   logic [W-1:0] word;
   logic         word_valid;
   logic         busy;
   logic         match;
   logic [3:0]   match_count;

   int checks = 0;
   int failures = 0;

   // Behavioural model state: bits of the current partial word and bits seen since the last sync.
   bit           m_frame[$];
   bit           m_hist[$];
   logic [W-1:0] m_word;
   logic         m_valid;
   logic         m_busy;
   logic         m_match;
   int           m_count;

   bit stream[W] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

   serial_word_receiver #(.WIDTH(W), .PATTERN(PAT)) dut (
      .clock       (clock),
      .clear       (clear),
      .serial_in   (serial_in),
      .enable      (enable),
      .sync        (sync),
      .word        (word),
      .word_valid  (word_valid),
      .busy        (busy),
      .match       (match),
      .match_count (match_count)
   );

   always #5 clock = ~clock;

   function automatic logic [W-1:0] qval(input bit q[$]);
      logic [W-1:0] v = '0;
      for (int i = 0; i < q.size(); i++) v[i] = q[i];
      return v;
   endfunction

   task automatic model_reset();
      m_frame.delete();
      m_hist.delete();
      m_word  = '0;
      m_valid = 1'b0;
      m_busy  = 1'b0;
      m_match = 1'b0;
      m_count = 0;
   endtask

   task automatic model_step(input bit b, input bit en, input bit sy);
      m_valid = 1'b0;
      m_match = 1'b0;
      if (sy) begin
         m_frame.delete();
         m_hist.delete();
      end
      if (en) begin
         m_frame.push_back(b);
         m_hist.push_back(b);
         if (m_hist.size() > W) void'(m_hist.pop_front());
         if (m_frame.size() == W) begin
            m_word  = qval(m_frame);
            m_valid = 1'b1;
            m_frame.delete();
         end
         if (m_hist.size() == W && qval(m_hist) == PAT) begin
            m_match = 1'b1;
            if (m_count < 15) m_count++;
         end
      end
      m_busy = (m_frame.size() != 0);
   endtask

   task automatic step(input bit b, input bit en, input bit sy);
      @(negedge clock);
      serial_in = b;
      enable    = en;
      sync      = sy;
      @(posedge clock);
      #1;
      model_step(b, en, sy);
   endtask

   task automatic reset_dut();
      @(negedge clock);
      enable    = 1'b0;
      sync      = 1'b0;
      serial_in = 1'b0;
      clear     = 1'b1;
      #2;
      clear = 1'b0;
      model_reset();
   endtask

   task automatic test_reset();
      int vcount = 0;
      reset_dut();
      for (int i = 0; i < W; i++) step(stream[i], 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      enable = 1'b0;
      #2;
      clear = 1'b1;
      #1;
      checks++; if (word !== '0) begin failures++; $display("FAIL reset_word: got %b expected %b", word, 5'b0); end
      checks++; if (word_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", word_valid); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (match !== 1'b0) begin failures++; $display("FAIL reset_match: got %b expected 0", match); end
      checks++; if (match_count !== 4'd0) begin failures++; $display("FAIL reset_count: got %0d expected 0", match_count); end
      @(negedge clock);
      #1;
      clear = 1'b0;
      model_reset();
      for (int i = 0; i < W; i++) begin
         step(stream[i], 1'b1, 1'b0);
         if (word_valid === 1'b1) vcount++;
      end
      checks++; if (word !== 5'b10110) begin failures++; $display("FAIL post_reset_word: got %b expected %b", word, 5'b10110); end
      checks++; if (vcount != 1) begin failures++; $display("FAIL post_reset_valid_pulses: got %0d expected 1", vcount); end
   endtask

   task automatic test_back_to_back();
      int vcount = 0;
      reset_dut();
      for (int i = 0; i < 2 * W; i++) begin
         step(stream[i % W], 1'b1, 1'b0);
         checks++;
         if (word_valid !== ((i % W) == W - 1)) begin
            failures++; $display("FAIL b2b_valid bit %0d: got %b expected %b", i, word_valid, (i % W) == W - 1);
         end
         if (word_valid === 1'b1) begin
            vcount++;
            checks++; if (word !== 5'b10110) begin failures++; $display("FAIL b2b_word: got %b expected %b", word, 5'b10110); end
         end
      end
      checks++; if (match_count !== 4'd2) begin failures++; $display("FAIL b2b_count: got %0d expected 2", match_count); end
      checks++; if (vcount != 2) begin failures++; $display("FAIL b2b_pulses: got %0d expected 2", vcount); end
   endtask

   task automatic test_gaps();
      bit bits[W] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      int vcount = 0;
      reset_dut();
      for (int k = 0; k < W; k++) begin
         step(bits[k], 1'b1, 1'b0);
         if (word_valid === 1'b1) vcount++;
         if (k < W - 1) begin
            for (int g = 0; g < 3; g++) begin
               step(1'b0, 1'b0, 1'b0);
               checks++; if (busy !== 1'b1) begin failures++; $display("FAIL gaps_busy after bit %0d: got %b expected 1", k, busy); end
               if (word_valid === 1'b1) vcount++;
            end
         end
      end
      checks++; if (word !== 5'b00001) begin failures++; $display("FAIL gaps_word: got %b expected %b", word, 5'b00001); end
      checks++; if (vcount != 1) begin failures++; $display("FAIL gaps_pulses: got %0d expected 1", vcount); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL gaps_busy_done: got %b expected 0", busy); end
   endtask

   task automatic test_sync_mid();
      int mcount = 0;
      reset_dut();
      for (int i = 0; i < 3; i++) step(1'($urandom_range(0, 1)), 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b1);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL sync_mid_busy: got %b expected 0", busy); end
      for (int i = 0; i < W; i++) begin
         step(1'b1, 1'b1, 1'b0);
         if (match === 1'b1) mcount++;
      end
      checks++; if (word !== 5'b11111) begin failures++; $display("FAIL sync_mid_word: got %b expected %b", word, 5'b11111); end
      checks++; if (mcount != 0) begin failures++; $display("FAIL sync_mid_match: got %0d expected 0", mcount); end
      checks++; if (match_count !== 4'd0) begin failures++; $display("FAIL sync_mid_count: got %0d expected 0", match_count); end
   endtask

   task automatic test_sync_bit();
      int vcount = 0;
      reset_dut();
      step(1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b1);
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL sync_bit_busy: got %b expected 1", busy); end
      for (int i = 0; i < W - 1; i++) begin
         step(1'b0, 1'b1, 1'b0);
         if (word_valid === 1'b1) vcount++;
      end
      checks++; if (word !== 5'b00001) begin failures++; $display("FAIL sync_bit_word: got %b expected %b", word, 5'b00001); end
      checks++; if (vcount != 1) begin failures++; $display("FAIL sync_bit_pulses: got %0d expected 1", vcount); end
   endtask

   task automatic test_saturation();
      int mpulses = 0;
      int exp_count;
      reset_dut();
      for (int i = 0; i < 100; i++) begin
         step(stream[i % W], 1'b1, 1'b0);
         exp_count = ((i + 1) / W > 15) ? 15 : (i + 1) / W;
         checks++;
         if (match !== ((i % W) == W - 1)) begin
            failures++; $display("FAIL sat_match bit %0d: got %b expected %b", i, match, (i % W) == W - 1);
         end
         checks++;
         if (match_count !== 4'(exp_count)) begin
            failures++; $display("FAIL sat_count bit %0d: got %0d expected %0d", i, match_count, exp_count);
         end
         if (match === 1'b1) mpulses++;
      end
      checks++; if (mpulses != 20) begin failures++; $display("FAIL sat_pulses: got %0d expected 20", mpulses); end
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
      checks++; if (match_count !== 4'd15) begin failures++; $display("FAIL sat_hold: got %0d expected 15", match_count); end
      checks++; if (match !== 1'b0) begin failures++; $display("FAIL sat_idle_match: got %b expected 0", match); end
   endtask

   task automatic test_random();
      bit b, en, sy;
      reset_dut();
      for (int i = 0; i < 400; i++) begin
         b  = 1'($urandom_range(0, 1));
         en = ($urandom_range(0, 9) < 7);
         sy = ($urandom_range(0, 19) == 0);
         // Bias some stretches towards the pattern so matches actually occur.
         if ((i / 40) % 2 == 1) b = stream[i % W];
         step(b, en, sy);
         checks++; if (word !== m_word) begin failures++; $display("FAIL rand_word cyc %0d: got %b expected %b", i, word, m_word); end
         checks++; if (word_valid !== m_valid) begin failures++; $display("FAIL rand_valid cyc %0d: got %b expected %b", i, word_valid, m_valid); end
         checks++; if (busy !== m_busy) begin failures++; $display("FAIL rand_busy cyc %0d: got %b expected %b", i, busy, m_busy); end
         checks++; if (match !== m_match) begin failures++; $display("FAIL rand_match cyc %0d: got %b expected %b", i, match, m_match); end
         checks++; if (match_count !== 4'(m_count)) begin failures++; $display("FAIL rand_count cyc %0d: got %0d expected %0d", i, match_count, m_count); end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_back_to_back();
      test_gaps();
      test_sync_mid();
      test_sync_bit();
      test_saturation();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
